// File: rtl/cc_pkg.sv
// Shared constants and types for the cache-controller read-response scheduler.
package cc_pkg;

    localparam int CC_LINE_W  = 512;
    localparam int CC_OFS_W   = 6;
    localparam int CC_BEAT_W  = 64;
    localparam int CC_BEATS   = 8;
    localparam int CC_ENTRY_W = CC_OFS_W + CC_LINE_W;

    typedef struct packed {
        logic [CC_OFS_W-1:0]  ofs;
        logic [CC_LINE_W-1:0] line;
    } cc_line_entry_t;

    typedef enum logic {
        IDLE,
        BURST
    } cc_rsp_state_t;

    typedef enum logic {
        SRC_HIT,
        SRC_FILL
    } cc_src_t;

endpackage

// File: rtl/cc_rr_arb2.sv
// Two-way arbiter: round-robin between req[0]=HIT and req[1]=FILL, or FILL-first when
// fixed_prio is set. The pointer moves only when advance accepts a grant.
module cc_rr_arb2
    import cc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       fixed_prio,
    output logic [1:0] gnt
);

    cc_src_t favour_q;

    always_comb begin
        gnt = 2'b00;
        if (fixed_prio) begin
            if (req[1]) begin
                gnt = 2'b10;
            end else if (req[0]) begin
                gnt = 2'b01;
            end
        end else if (req == 2'b11) begin
            gnt = (favour_q == SRC_FILL) ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

    // After each grant, favour the source that just lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            favour_q <= SRC_HIT;
        end else if (advance && (gnt != 2'b00)) begin
            favour_q <= gnt[0] ? SRC_FILL : SRC_HIT;
        end
    end

endmodule

// File: rtl/cc_line_resp_sched.sv
// Read-response scheduler: pops whole lines from the HIT/FILL FIFOs and streams each one as
// 8 beats, critical word first with wrap, back-to-back lines without a bubble.
//
//  state | meaning
//  IDLE  | no line held; grant as soon as either FIFO is non-empty
//  BURST | streaming the held line; regrant on the accepted final beat
module cc_line_resp_sched
    import cc_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hit_empty_i,
    input  logic [CC_ENTRY_W-1:0] hit_rdata_i,
    output logic                  hit_rden_o,
    input  logic                  fill_empty_i,
    input  logic [CC_ENTRY_W-1:0] fill_rdata_i,
    output logic                  fill_rden_o,
    output logic [CC_BEAT_W-1:0]  rdata_o,
    output logic                  rsrc_o,
    output logic                  rlast_o,
    output logic                  rvalid_o,
    input  logic                  rready_i
);

    localparam logic [2:0] CNT_LAST = 3'(CC_BEATS - 1);

    cc_rsp_state_t  state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    cc_line_entry_t entry_q;
    cc_src_t        src_q;
    logic [1:0]     req;
    logic [1:0]     gnt;
    logic           grant;
    logic [2:0]     word_idx;
    logic [CC_BEAT_W-1:0] words [CC_BEATS];
    logic           unused_ofs_lsb;

    assign req = {~fill_empty_i, ~hit_empty_i};

    cc_rr_arb2 u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .advance    (grant),
        .fixed_prio (FIXED_PRIO != 0),
        .gnt        (gnt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    grant   = 1'b1;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (rready_i) begin
                    if (cnt_q == CNT_LAST) begin
                        if (req != 2'b00) begin
                            grant = 1'b1;
                        end else begin
                            state_d = IDLE;
                            cnt_d   = 3'd0;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Held in reset, the FIFOs must not be popped even though the FSM sits in IDLE.
        grant = grant & rst_n;
        if (grant) begin
            cnt_d = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            entry_q <= '0;
            src_q   <= SRC_HIT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (grant) begin
                entry_q <= gnt[1] ? fill_rdata_i : hit_rdata_i;
                src_q   <= gnt[1] ? SRC_FILL : SRC_HIT;
            end
        end
    end

    // Word 0 is the most significant 64 bits of the line.
    for (genvar w = 0; w < CC_BEATS; w++) begin : g_words
        assign words[w] = entry_q.line[CC_LINE_W-1-CC_BEAT_W*w -: CC_BEAT_W];
    end

    assign word_idx       = entry_q.ofs[5:3] + cnt_q;
    assign unused_ofs_lsb = ^entry_q.ofs[2:0];

    assign rvalid_o    = (state_q == BURST);
    assign rdata_o     = rvalid_o ? words[word_idx] : '0;
    assign rlast_o     = rvalid_o && (cnt_q == CNT_LAST);
    assign rsrc_o      = (src_q == SRC_FILL);
    assign hit_rden_o  = grant & gnt[0];
    assign fill_rden_o = grant & gnt[1];

endmodule

// File: tb/tb_cc_line_resp_sched.sv
// Bench for cc_line_resp_sched: one round-robin and one fixed-priority instance, each fed by
// its own pair of show-ahead FIFO models.
module tb_cc_line_resp_sched;

    logic clk = 1'b0;
    logic rst_n;
    logic rready;
    logic tb_init;

    logic         hit_empty  [2];
    logic [517:0] hit_rdata  [2];
    logic         hit_rden   [2];
    logic         fill_empty [2];
    logic [517:0] fill_rdata [2];
    logic         fill_rden  [2];
    logic [63:0]  rdata      [2];
    logic         rsrc       [2];
    logic         rlast      [2];
    logic         rvalid     [2];

    logic [517:0] hmem [2][32];
    logic [517:0] fmem [2][32];
    logic [4:0]   hwr [2], hrd [2], fwr [2], frd [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cc_line_resp_sched #(.FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .hit_empty_i(hit_empty[0]), .hit_rdata_i(hit_rdata[0]), .hit_rden_o(hit_rden[0]),
        .fill_empty_i(fill_empty[0]), .fill_rdata_i(fill_rdata[0]), .fill_rden_o(fill_rden[0]),
        .rdata_o(rdata[0]), .rsrc_o(rsrc[0]), .rlast_o(rlast[0]), .rvalid_o(rvalid[0]),
        .rready_i(rready)
    );

    cc_line_resp_sched #(.FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .hit_empty_i(hit_empty[1]), .hit_rdata_i(hit_rdata[1]), .hit_rden_o(hit_rden[1]),
        .fill_empty_i(fill_empty[1]), .fill_rdata_i(fill_rdata[1]), .fill_rden_o(fill_rden[1]),
        .rdata_o(rdata[1]), .rsrc_o(rsrc[1]), .rlast_o(rlast[1]), .rvalid_o(rvalid[1]),
        .rready_i(rready)
    );

    for (genvar d = 0; d < 2; d++) begin : g_fifo
        assign hit_empty[d]  = (hrd[d] == hwr[d]);
        assign hit_rdata[d]  = hmem[d][hrd[d]];
        assign fill_empty[d] = (frd[d] == fwr[d]);
        assign fill_rdata[d] = fmem[d][frd[d]];
        always @(posedge clk) begin
            if (tb_init) begin
                hrd[d] <= 5'd0;
                frd[d] <= 5'd0;
            end else begin
                if (hit_rden[d])  hrd[d] <= hrd[d] + 5'd1;
                if (fill_rden[d]) frd[d] <= frd[d] + 5'd1;
            end
        end
    end

    // Word w of a line carries {tag, w}; word 0 ends up in the top 64 bits.
    function automatic logic [511:0] mk_line(input logic [31:0] tag);
        logic [511:0] l;
        l = '0;
        for (int w = 0; w < 8; w++) l = {l[447:0], tag, 32'(w)};
        return l;
    endfunction

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h required=%0h @%0t", nm, d, act, exp, $time);
        end
    endtask

    task automatic push(input logic src, input logic [5:0] ofs, input logic [31:0] tag);
        for (int d = 0; d < 2; d++) begin
            if (!src) begin
                hmem[d][hwr[d]] = {ofs, mk_line(tag)};
                hwr[d] = hwr[d] + 5'd1;
            end else begin
                fmem[d][fwr[d]] = {ofs, mk_line(tag)};
                fwr[d] = fwr[d] + 5'd1;
            end
        end
    endtask

    task automatic chk_beat(input int d, input logic [31:0] tag, input int first, input int k,
                            input logic src);
        chk("rvalid", d, 64'(rvalid[d]), 64'd1);
        chk("rdata", d, rdata[d], {tag, 32'((first + k) % 8)});
        chk("rlast", d, 64'(rlast[d]), 64'(k == 7));
        chk("rsrc", d, 64'(rsrc[d]), 64'(src));
    endtask

    // Single line through an idle scheduler with rready held high.
    task automatic run_line(input logic src, input logic [5:0] ofs, input logic [31:0] tag,
                            input int first);
        @(negedge clk);
        push(src, ofs, tag);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("grant_hit_rden", d, 64'(hit_rden[d]), 64'(!src));
            chk("grant_fill_rden", d, 64'(fill_rden[d]), 64'(src));
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk_beat(d, tag, first, k, src);
                chk("burst_rden", d, 64'(hit_rden[d] | fill_rden[d]), 64'd0);
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("idle_rvalid", d, 64'(rvalid[d]), 64'd0);
    endtask

    typedef struct {
        logic        src;
        logic [5:0]  ofs;
        logic [31:0] tag;
        int          first;
    } vec_t;

    vec_t vecs [6];

    logic [31:0] exp_tag   [2][4];
    int          exp_first [2][4];
    logic        exp_src   [2][4];
    int          rden_cnt  [2];
    logic        rdy_pat   [12];

    initial begin
        vecs[0] = '{1'b0, 6'h00, 32'h101, 0};
        vecs[1] = '{1'b1, 6'h2C, 32'h102, 5};
        vecs[2] = '{1'b0, 6'h3F, 32'h103, 7};
        vecs[3] = '{1'b1, 6'h07, 32'h104, 0};
        vecs[4] = '{1'b1, 6'h38, 32'h105, 7};
        vecs[5] = '{1'b0, 6'h15, 32'h106, 2};

        exp_tag[0]   = '{32'h11, 32'h21, 32'h12, 32'h22};
        exp_first[0] = '{0, 2, 1, 7};
        exp_src[0]   = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_tag[1]   = '{32'h21, 32'h22, 32'h11, 32'h12};
        exp_first[1] = '{2, 7, 0, 1};
        exp_src[1]   = '{1'b1, 1'b1, 1'b0, 1'b0};

        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        for (int d = 0; d < 2; d++) begin
            hwr[d] = 5'd0;
            fwr[d] = 5'd0;
        end
        rst_n   = 1'b0;
        tb_init = 1'b1;
        rready  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_rvalid", d, 64'(rvalid[d]), 64'd0);
            chk("rst_rlast", d, 64'(rlast[d]), 64'd0);
            chk("rst_rdata", d, rdata[d], 64'd0);
            chk("rst_rsrc", d, 64'(rsrc[d]), 64'd0);
            chk("rst_rden", d, 64'(hit_rden[d] | fill_rden[d]), 64'd0);
        end
        tb_init = 1'b0;
        rst_n   = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_line(vecs[i].src, vecs[i].ofs, vecs[i].tag, vecs[i].first);
        end

        // Two lines in each FIFO: arbitration order and zero-bubble streaming.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push(1'b0, 6'h00, 32'h11);
        push(1'b0, 6'h08, 32'h12);
        push(1'b1, 6'h10, 32'h21);
        push(1'b1, 6'h3F, 32'h22);
        #1;
        for (int d = 0; d < 2; d++) rden_cnt[d] = int'(hit_rden[d]) + int'(fill_rden[d]);
        for (int b = 0; b < 32; b++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk_beat(d, exp_tag[d][b / 8], exp_first[d][b / 8], b % 8, exp_src[d][b / 8]);
                rden_cnt[d] += int'(hit_rden[d]) + int'(fill_rden[d]);
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            rden_cnt[d] += int'(hit_rden[d]) + int'(fill_rden[d]);
            chk("b2b_end_rvalid", d, 64'(rvalid[d]), 64'd0);
            chk("b2b_rden_count", d, 64'(rden_cnt[d]), 64'd4);
        end

        // Back-pressure: beats advance only on handshake, data holds while stalled.
        begin
            int k;
            k = 0;
            @(negedge clk);
            push(1'b0, 6'h18, 32'h31);
            #1;
            for (int d = 0; d < 2; d++) chk("stall_grant", d, 64'(hit_rden[d]), 64'd1);
            for (int i = 0; i < 12; i++) begin
                if (k < 8) begin
                    @(negedge clk);
                    for (int d = 0; d < 2; d++) begin
                        chk_beat(d, 32'h31, 3, k, 1'b0);
                        chk("stall_rden", d, 64'(hit_rden[d] | fill_rden[d]), 64'd0);
                    end
                    rready = rdy_pat[i];
                    if (rready) k++;
                end
            end
            chk("stall_beats", 0, 64'(k), 64'd8);
            @(negedge clk);
            rready = 1'b1;
            for (int d = 0; d < 2; d++) chk("stall_end_rvalid", d, 64'(rvalid[d]), 64'd0);
        end

        // Reset during beat 3 discards the line; a fresh line afterwards starts cleanly.
        @(negedge clk);
        push(1'b1, 6'h08, 32'h41);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) chk_beat(d, 32'h41, 1, k, 1'b1);
        end
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rstmid_rvalid", d, 64'(rvalid[d]), 64'd0);
            chk("rstmid_rlast", d, 64'(rlast[d]), 64'd0);
            chk("rstmid_rdata", d, rdata[d], 64'd0);
            chk("rstmid_rden", d, 64'(hit_rden[d] | fill_rden[d]), 64'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk("post_rst_rvalid", d, 64'(rvalid[d]), 64'd0);
                chk("post_rst_rden", d, 64'(hit_rden[d] | fill_rden[d]), 64'd0);
            end
        end
        run_line(1'b0, 6'h30, 32'h42, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
